// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-L2 cache arbiter: FSM states, grant side and latched op.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } req_op_t;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side not granted last.
module arbiter_grant
    import arbiter_types::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output logic   grant_valid,
    output grant_t grant
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant       = GRANT_I;
        if (i_req && d_req) begin
            grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single L2 port between I-cache misses and D-cache misses/writebacks,
// one latched line transaction at a time, with the response routed only to the winner.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] icache_arbi_address,
    input  logic              icache_arbi_read,
    output logic [LINE_W-1:0] icache_arbi_rdata,
    output logic              icache_arbi_resp,

    input  logic [ADDR_W-1:0] dcache_arbi_address,
    input  logic [LINE_W-1:0] dcache_arbi_wdata,
    input  logic              dcache_arbi_read,
    input  logic              dcache_arbi_write,
    output logic [LINE_W-1:0] dcache_arbi_rdata,
    output logic              dcache_arbi_resp,

    output logic [ADDR_W-1:0] arbi_l2_address,
    output logic [LINE_W-1:0] arbi_l2_wdata,
    output logic              arbi_l2_read,
    output logic              arbi_l2_write,
    input  logic [LINE_W-1:0] arbi_l2_rdata,
    input  logic              arbi_l2_resp
);

    arb_state_t        state;
    arb_state_t        state_next;
    grant_t            last_grant;
    grant_t            grant;
    logic              grant_valid;
    logic              load;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    req_op_t           req_op;

    arbiter_grant u_grant (
        .i_req       (icache_arbi_read),
        .d_req       (dcache_arbi_read | dcache_arbi_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's request so requester-side changes during SERVE are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            req_op     <= OP_READ;
            last_grant <= GRANT_D;
        end else if (load) begin
            last_grant <= grant;
            if (grant == GRANT_I) begin
                req_addr  <= icache_arbi_address;
                req_wdata <= '0;
                req_op    <= OP_READ;
            end else begin
                req_addr  <= dcache_arbi_address;
                req_wdata <= dcache_arbi_wdata;
                req_op    <= dcache_arbi_write ? OP_WRITE : OP_READ;
            end
        end
    end

    always_comb begin
        state_next        = state;
        load              = 1'b0;
        arbi_l2_address   = '0;
        arbi_l2_wdata     = '0;
        arbi_l2_read      = 1'b0;
        arbi_l2_write     = 1'b0;
        icache_arbi_resp  = 1'b0;
        icache_arbi_rdata = '0;
        dcache_arbi_resp  = 1'b0;
        dcache_arbi_rdata = '0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    load       = 1'b1;
                    state_next = (grant == GRANT_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I: begin
                arbi_l2_address = req_addr;
                arbi_l2_wdata   = req_wdata;
                arbi_l2_read    = (req_op == OP_READ);
                arbi_l2_write   = (req_op == OP_WRITE);
                if (arbi_l2_resp) begin
                    icache_arbi_resp  = 1'b1;
                    icache_arbi_rdata = arbi_l2_rdata;
                    state_next        = RELEASE;
                end
            end
            SERVE_D: begin
                arbi_l2_address = req_addr;
                arbi_l2_wdata   = req_wdata;
                arbi_l2_read    = (req_op == OP_READ);
                arbi_l2_write   = (req_op == OP_WRITE);
                if (arbi_l2_resp) begin
                    dcache_arbi_resp  = 1'b1;
                    dcache_arbi_rdata = arbi_l2_rdata;
                    state_next        = RELEASE;
                end
            end
            // Dead cycle so the served requester has dropped its level request.
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
